// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU (MAR/MDR) port and a DMA/loader port.
// Build option ARB_ROUND_ROBIN_EN: ties alternate between ports; otherwise the CPU wins ties.
module ram_port_arbiter #(
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          clr,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  // DMA / loader port
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  input  logic          dma_lock,
  // RAM side
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned LcW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [LcW-1:0] LockLast = LcW'(LOCK_MAX - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCpuAcc,
    StDmaAcc,
    StCpuDone,
    StDmaDone
  } state_e;

  state_e         state_q;
  logic [LcW-1:0] lock_cnt_q;
  logic           acc_we_q;
  logic           cpu_gnt_q;
  logic           cpu_done_q;
  logic           dma_gnt_q;
  logic           dma_done_q;
  logic [DW-1:0]  cpu_rdata_q;
  logic [DW-1:0]  dma_rdata_q;
  logic [AW-1:0]  ram_addr_q;
  logic           ram_we_q;
  logic [DW-1:0]  ram_wdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic           last_dma_q;
`endif

  logic can_grant;
  logic lock_hold;
  logic lock_release;
  logic grant_cpu;
  logic grant_dma;

  // Grant decision, only acted upon in states that can start a new access.
  always_comb begin
    grant_cpu    = 1'b0;
    grant_dma    = 1'b0;
    can_grant    = (state_q == StIdle) || (state_q == StCpuDone) || (state_q == StDmaDone);
    lock_hold    = (state_q == StDmaDone) && dma_req && dma_lock;
    lock_release = lock_hold && cpu_req && (lock_cnt_q == LockLast);
    if (can_grant) begin
      if (lock_release) begin
        grant_cpu = 1'b1;
      end else if (lock_hold) begin
        grant_dma = 1'b1;
      end else if (cpu_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_cpu = last_dma_q;
        grant_dma = !last_dma_q;
`else
        grant_cpu = 1'b1;
`endif
      end else begin
        grant_cpu = cpu_req;
        grant_dma = dma_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      lock_cnt_q  <= '0;
      acc_we_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_gnt_q   <= 1'b0;
      dma_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dma_q  <= 1'b1;
`endif
    end else begin
      cpu_gnt_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      dma_gnt_q  <= 1'b0;
      dma_done_q <= 1'b0;
      ram_we_q   <= 1'b0;

      case (state_q)
        StCpuAcc: begin
          state_q    <= StCpuDone;
          cpu_done_q <= 1'b1;
        end
        StDmaAcc: begin
          state_q    <= StDmaDone;
          dma_done_q <= 1'b1;
        end
        StIdle, StCpuDone, StDmaDone: begin
          if (state_q == StCpuDone && !acc_we_q) begin
            cpu_rdata_q <= ram_rdata;
          end
          if (state_q == StDmaDone && !acc_we_q) begin
            dma_rdata_q <= ram_rdata;
          end
          if (grant_cpu) begin
            state_q     <= StCpuAcc;
            cpu_gnt_q   <= 1'b1;
            acc_we_q    <= cpu_we;
            ram_we_q    <= cpu_we;
            ram_addr_q  <= cpu_addr;
            ram_wdata_q <= cpu_wdata;
          end else if (grant_dma) begin
            state_q     <= StDmaAcc;
            dma_gnt_q   <= 1'b1;
            acc_we_q    <= dma_we;
            ram_we_q    <= dma_we;
            ram_addr_q  <= dma_addr;
            ram_wdata_q <= dma_wdata;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Counts locked DMA repeats that keep a waiting CPU out.
      if (!dma_lock || grant_cpu) begin
        lock_cnt_q <= '0;
      end else if (lock_hold && !lock_release && cpu_req) begin
        lock_cnt_q <= lock_cnt_q + LcW'(1);
      end

`ifdef ARB_ROUND_ROBIN_EN
      if (grant_cpu) begin
        last_dma_q <= 1'b0;
      end else if (grant_dma) begin
        last_dma_q <= 1'b1;
      end
`endif
    end
  end

  // The RAM returns read data in the done cycle, so pass it straight through there.
  assign cpu_rdata = (state_q == StCpuDone && !acc_we_q) ? ram_rdata : cpu_rdata_q;
  assign dma_rdata = (state_q == StDmaDone && !acc_we_q) ? ram_rdata : dma_rdata_q;

  assign cpu_gnt   = cpu_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign dma_gnt   = dma_gnt_q;
  assign dma_done  = dma_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter for the single-port 64x16 data RAM. It shares the RAM between the processor's MAR/MDR path (CPU port) and a DMA/loader port that fills or dumps data memory while the controller runs. Each requester gets a req/gnt/done handshake. The arbiter sequences every access through a small state machine, and a bounded DMA lock provides burst transfers without starving the CPU.

## Interface
Parameters:
- AW, 6, RAM address width (64 words)
- DW, 16, data width
- LOCK_MAX, 16, maximum consecutive DMA accesses under lock while the CPU is waiting

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_done
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  AW  CPU address (from MAR)
- cpu_wdata  in  DW  CPU write data (from MDR)
- cpu_gnt  out  1  CPU owns the RAM this cycle
- cpu_done  out  1  one-cycle pulse: access complete, cpu_rdata valid
- cpu_rdata  out  DW  read data, held until the next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata: same as the CPU set, for the DMA port
- dma_lock  in  1  keep DMA ownership for back-to-back accesses
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, registered inside the RAM (valid the cycle after the address)

## Operation
- FSM states:
  - IDLE
  - CPU_ACC: address phase, cpu_gnt=1
  - DMA_ACC: address phase, dma_gnt=1
  - CPU_DONE: cpu_rdata captured, cpu_done=1
  - DMA_DONE: dma_rdata captured, dma_done=1
- IDLE:
  - only cpu_req → CPU_ACC; only dma_req → DMA_ACC; neither → stay
  - both requesting → winner chosen by the policy (see Configuration)
- X_ACC: ram_addr/ram_wdata driven from port X; ram_we = X_we for exactly this one cycle → X_DONE.
- X_DONE:
  - read: X_rdata ← ram_rdata
  - write: X_rdata unchanged
  - X_done pulses for both reads and writes
  - next state is chosen as in IDLE, so back-to-back accesses run at one access per 2 cycles
- DMA lock:
  - In DMA_DONE with dma_req && dma_lock, DMA wins again regardless of policy.
  - lock_cnt increments each locked repeat while cpu_req=1.
  - When lock_cnt reaches LOCK_MAX-1 with cpu_req pending, the CPU is granted next.
  - lock_cnt clears on any CPU grant or when dma_lock=0.
- Outside X_ACC: ram_we=0; ram_addr/ram_wdata hold their last values.
- Dropping req during X_ACC does not abort the access; done still pulses.
- Requests must stay stable until done. Changing addr/we while granted is a protocol error; the values sampled in X_ACC are used.
- gnt and done are never both high for the same port in the same cycle.
- At most one gnt is high in any cycle.

## Timing
- Reset (clr high at an edge):
  - FSM → IDLE
  - all gnt/done/ram_we = 0
  - ram_addr=0, ram_wdata=0, cpu_rdata=0, dma_rdata=0
  - lock_cnt=0, last_winner=DMA (so the CPU wins the first tie)
- Reset during X_ACC aborts the access. ram_we is 0 from the reset edge, and no done is issued.
- Latency from req rising in IDLE: gnt in cycle +1, done in cycle +2.
- Worst-case CPU wait under a DMA lock: 2*LOCK_MAX cycles plus the in-flight access.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: a tie goes to the port that did not win last; last_winner updates on every grant.
  - Undefined: fixed priority, CPU always wins ties. DMA lock and LOCK_MAX starvation release behave identically in both builds.

## Test plan
- Reset: clr=1 for 2 cycles with both req=1 → all outputs 0 and no grant; after clr falls, cpu_gnt=1 one cycle later.
- CPU write then read:
  - Write addr 6'h05, data 16'hBEEF → ram_we=1 for exactly 1 cycle and cpu_done 1 cycle later.
  - Read addr 6'h05 → cpu_rdata=16'hBEEF on the cpu_done cycle.
- Simultaneous requests, 4 accesses each:
  - ARB_ROUND_ROBIN_EN defined → grants alternate CPU, DMA, CPU, DMA…
  - Undefined → all 4 CPU accesses complete first.
- DMA burst: dma_lock=1, 40 DMA writes, cpu_req=1 throughout → CPU granted after exactly 16 consecutive DMA accesses; DMA resumes after cpu_done.
- Reset mid-access: clr asserted during DMA_ACC of a write → ram_we=0 on the next edge, no dma_done, FSM in IDLE.
- Request dropped during CPU_ACC → access completes, cpu_done pulses once, FSM returns to IDLE.
